// File: rtl/alu_ctrl_sequencer.sv
// alu_ctrl_sequencer: control-side initiator for the alu_reg_ram datapath.
// Accepts 32-bit micro-instructions, drives register/ALU/RAM controls through
// ISSUE -> [WAIT] -> WRITE -> DONE, captures status/Cout and counts retires.
// Optional macro CARRY_CHAIN_EN: cin comes from the previously captured carry.
module alu_ctrl_sequencer #(
   parameter int ALU_WAIT = 0,   // extra settle cycles between ISSUE and WRITE (0..15)
   parameter int RETIRE_W = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [31:0]         instr,
   input  logic [3:0]          status,
   input  logic                Cout,
   output logic                write,
   output logic [4:0]          writeReg,
   output logic [63:0]         data,
   output logic [4:0]          readA,
   output logic [4:0]          readB,
   output logic [4:0]          sel,
   output logic                muxSel,
   output logic                cin,
   output logic                writeRam,
   output logic                done,
   output logic [3:0]          flags,
   output logic                carry_flag,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic                ready_q, wen_q, wram_q;
   logic                write_q, writeRam_q, done_q;
   logic [4:0]          writeReg_q, readA_q, readB_q, sel_q;
   logic                muxSel_q, cin_q, carry_q;
   logic [7:0]          imm_q;
   logic [3:0]          flags_q;
   logic [RETIRE_W-1:0] retired_q;

   logic                cin_d;
   logic [RETIRE_W-1:0] retired_d;

   // carry-in source for the instruction being accepted, and the next retire count
   always_comb begin
      retired_d = retired_q + RETIRE_W'(1);
`ifdef CARRY_CHAIN_EN
      cin_d = instr[10] & carry_q;
`else
      cin_d = instr[10];
`endif
   end

   // sequencing FSM; every output is a register loaded on the transition into its state
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         ready_q    <= 1'b0;
         wen_q      <= 1'b0;
         wram_q     <= 1'b0;
         write_q    <= 1'b0;
         writeRam_q <= 1'b0;
         done_q     <= 1'b0;
         writeReg_q <= 5'd0;
         readA_q    <= 5'd0;
         readB_q    <= 5'd0;
         sel_q      <= 5'd0;
         muxSel_q   <= 1'b0;
         cin_q      <= 1'b0;
         carry_q    <= 1'b0;
         imm_q      <= 8'd0;
         flags_q    <= 4'd0;
         retired_q  <= '0;
      end else begin
         // strobes are single-cycle unless re-asserted below
         write_q    <= 1'b0;
         writeRam_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (instr_valid && ready_q) begin
                  // fields land now so they are visible throughout ISSUE
                  ready_q    <= 1'b0;
                  sel_q      <= instr[31:27];
                  writeReg_q <= instr[26:22];
                  readA_q    <= instr[21:17];
                  readB_q    <= instr[16:12];
                  muxSel_q   <= instr[11];
                  cin_q      <= cin_d;
                  wram_q     <= instr[9];
                  wen_q      <= instr[8];
                  imm_q      <= instr[7:0];
                  state_q    <= S_ISSUE;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (ALU_WAIT == 0) begin
                  write_q    <= wen_q;
                  writeRam_q <= wram_q;
                  state_q    <= S_WRITE;
               end else begin
                  cnt_q   <= 4'(ALU_WAIT - 1);
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  write_q    <= wen_q;
                  writeRam_q <= wram_q;
                  state_q    <= S_WRITE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_WRITE: begin
               flags_q <= status;
               carry_q <= Cout;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               retired_q <= retired_d;
               ready_q   <= 1'b1;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // a ready seen during reset would be discarded, so mask it
   assign instr_ready = ready_q & ~reset;
   assign write       = write_q;
   assign writeReg    = writeReg_q;
   assign data        = {56'd0, imm_q};
   assign readA       = readA_q;
   assign readB       = readB_q;
   assign sel         = sel_q;
   assign muxSel      = muxSel_q;
   assign cin         = cin_q;
   assign writeRam    = writeRam_q;
   assign done        = done_q;
   assign flags       = flags_q;
   assign carry_flag  = carry_q;
   assign retired     = retired_q;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Bench for alu_ctrl_sequencer: two instances (ALU_WAIT 0 and 3), each with a
// random driver pushing expectations into a queue and a monitor checking them.
module tb_alu_ctrl_sequencer;

   typedef struct {
      logic [31:0] ins;
      int          acc;
      logic        cin;
   } exp_t;

   localparam int NOPS = 60;
   localparam int HMAX = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int         cyc = 0;
   logic [3:0] status = 4'd0;
   logic       cout = 1'b0;
   logic [3:0] shist [HMAX];
   logic       chist [HMAX];
   int         nvec = 0;
   int         nerr = 0;
   bit         fin [2];

   task automatic chk(input int w, input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL w%0d %s: got %0h, expected %0h", w, nm, act, exp);
      end
   endtask

   // datapath status/Cout change every cycle; history records the value held in each cycle
   initial begin
      shist[0] = 4'd0;
      chist[0] = 1'b0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         status = 4'($urandom);
         cout   = 1'($urandom);
         if (cyc < HMAX) begin
            shist[cyc] = status;
            chist[cyc] = cout;
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int W = (g == 0) ? 0 : 3;
      logic        rst, vld, rdy, wr, mux, ci, wram, dn, cf;
      logic [31:0] ins;
      logic [4:0]  wreg, ra, rb, sl;
      logic [63:0] dat;
      logic [3:0]  fl;
      logic [15:0] ret;
      exp_t        q[$];
      bit          directed;
      int          nret;

      alu_ctrl_sequencer #(.ALU_WAIT(W), .RETIRE_W(16)) dut (
         .clock(clk), .reset(rst), .instr_valid(vld), .instr_ready(rdy), .instr(ins),
         .status(status), .Cout(cout), .write(wr), .writeReg(wreg), .data(dat),
         .readA(ra), .readB(rb), .sel(sl), .muxSel(mux), .cin(ci), .writeRam(wram),
         .done(dn), .flags(fl), .carry_flag(cf), .retired(ret)
      );

      task automatic wait_accept(output int a, output bit ok);
         int t = 0;
         @(negedge clk);
         while (!rdy && t < 100) begin
            @(posedge clk); #1;
            @(negedge clk);
            t++;
         end
         ok = rdy;
         a  = cyc;
         if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL w%0d accept timeout: instr_ready got 0, expected 1", W);
         end
      endtask

      // driver and reference model
      initial begin
         int   acc, prev_acc, wc_prev, gap, t;
         bit   ok;
         logic prev_c, ecin;
         rst = 1'b1; vld = 1'b0; ins = '0; directed = 1'b1; nret = 0;
         repeat (2) @(posedge clk);
         @(negedge clk);
         chk(W, "reset ready", rdy, 0);
         chk(W, "reset write", wr, 0);
         chk(W, "reset done", dn, 0);
         chk(W, "reset retired", ret, 0);
         chk(W, "reset flags", {fl, cf, ci}, 0);
         @(posedge clk); #1;
         rst = 1'b0;

         // reset landing in the WRITE cycle aborts the instruction
         ins = {5'b10000, 5'd6, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
         vld = 1'b1;
         wait_accept(acc, ok);
         @(posedge clk); #1;
         vld = 1'b0;
         repeat (1 + W) begin @(posedge clk); #1; end
         rst = 1'b1;
         @(negedge clk);
         chk(W, "write in WRITE", {wr, wreg}, {1'b1, 5'd6});
         @(posedge clk); #1;
         rst = 1'b0;
         @(negedge clk);
         chk(W, "write after abort", wr, 0);
         chk(W, "done after abort", dn, 0);
         chk(W, "retired after abort", ret, 0);
         chk(W, "ready after abort", rdy, 0);
         @(posedge clk); #1;
         @(negedge clk);
         chk(W, "ready one cycle later", rdy, 1);
         directed = 1'b0;
         @(posedge clk); #1;

         prev_acc = 0;
         wc_prev  = -1;
         for (int n = 0; n < NOPS; n++) begin
            gap = (n < 6) ? 0 : $urandom_range(0, 2);
            vld = 1'b0;
            ins = $urandom;
            repeat (gap) begin @(posedge clk); #1; end
            ins = $urandom;
            vld = 1'b1;
            wait_accept(acc, ok);
            if (!ok) break;
            if (gap == 0 && n > 0) chk(W, "accept spacing", acc - prev_acc, 4 + W);
            prev_c = (wc_prev >= 0) ? chist[wc_prev] : 1'b0;
`ifdef CARRY_CHAIN_EN
            ecin = ins[10] & prev_c;
`else
            ecin = ins[10];
`endif
            q.push_back('{ins, acc, ecin});
            wc_prev  = acc + 2 + W;
            prev_acc = acc;
            @(posedge clk); #1;
         end
         vld = 1'b0;
         t = 0;
         while (q.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
         end
         if (q.size() > 0) begin
            nvec++;
            nerr++;
            $display("FAIL w%0d drain: %0d instructions outstanding, expected 0", W, q.size());
         end
         repeat (3) @(posedge clk);
         fin[g] = 1'b1;
      end

      // monitor: compares DUT outputs against queued expectations
      initial begin
         logic pw, pwr, pending;
         exp_t e;
         int   wcyc;
         pw = 1'b0; pwr = 1'b0; pending = 1'b0;
         forever begin
            @(negedge clk);
            if (pending) begin
               chk(W, "retired", ret, 16'(nret));
               pending = 1'b0;
            end
            if (q.size() > 0 && cyc >= q[0].acc + 1 && cyc <= q[0].acc + 3 + W)
               chk(W, "fields held", {sl, wreg, ra, rb, mux, ci, dat},
                   {q[0].ins[31:12], q[0].ins[11], q[0].cin, 56'd0, q[0].ins[7:0]});
            if (!directed && !rst && (wr || wram)) begin
               wcyc = (q.size() > 0) ? q[0].acc + 2 + W : -1;
               chk(W, "strobe cycle", cyc, wcyc);
            end
            if (dn) begin
               if (q.size() == 0) begin
                  nvec++;
                  nerr++;
                  $display("FAIL w%0d done: got unexpected pulse, expected none", W);
               end else begin
                  e = q.pop_front();
                  wcyc = e.acc + 2 + W;
                  chk(W, "done cycle", cyc, e.acc + 3 + W);
                  chk(W, "write strobe", pw, e.ins[8]);
                  chk(W, "writeRam strobe", pwr, e.ins[9]);
                  chk(W, "writeReg", wreg, e.ins[26:22]);
                  chk(W, "readA", ra, e.ins[21:17]);
                  chk(W, "readB", rb, e.ins[16:12]);
                  chk(W, "sel", sl, e.ins[31:27]);
                  chk(W, "muxSel", mux, e.ins[11]);
                  chk(W, "cin", ci, e.cin);
                  chk(W, "data", dat, {56'd0, e.ins[7:0]});
                  chk(W, "flags", fl, shist[wcyc]);
                  chk(W, "carry_flag", cf, chist[wcyc]);
                  nret++;
                  pending = 1'b1;
               end
            end
            pw  = wr;
            pwr = wram;
         end
      end
   end

   initial begin
      int t = 0;
      while (!(fin[0] && fin[1]) && t < 20000) begin
         @(posedge clk);
         t++;
      end
      if (!(fin[0] && fin[1])) begin
         nvec++;
         nerr++;
         $display("FAIL run timeout: drivers not finished after %0d cycles", t);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
